ysyx_22040237_lsu_mc: RTL and testbench
=======================================

// Module: ysyx_22040237_lsu_mc
// PURPOSE
//  Multi-cycle load/store unit between EXU and WBU. Accepts one op via valid/ready,
//  issues an aligned request on a handshaked memory port, waits for the response,
//  then aligns and sign/zero-extends load data. Parametrised in XLEN, with
//  byte-lane steering, a response timeout and error reporting.
// PARAMETERS
//  XLEN         64  datapath/bus width, 32 or 64; NB = XLEN/8 byte lanes, OFS_W = log2(NB)
//  TIMEOUT_CYC  256 max WAIT cycles before timeout error; 0 = no timeout
// PORTS
//  clk              in   1      clock
//  rst              in   1      synchronous reset, active-high
//  in_valid_i       in   1      op valid
//  in_ready_o       out  1      op accepted when valid&ready
//  rd_wr_en_i       in   1      writeback enable
//  rd_idx_i         in   5      dest reg
//  alu_res_i        in   XLEN   effective address / ALU result
//  ls_info_bus_i    in   7      {dw,word,half,byte,usign,store,load}, bit0 = load
//  rs2_store_i      in   XLEN   store data
//  out_valid_o      out  1      result valid
//  out_ready_i      in   1      WBU accepts result
//  rd_wr_en_o       out  1      writeback enable (0 on error)
//  rd_idx_o         out  5      dest reg
//  rd_data_o        out  XLEN   load data or pass-through ALU result
//  lsu_err_o        out  1      access fault, qualified by out_valid_o
//  mem_req_valid_o  out  1      memory request valid
//  mem_req_ready_i  in   1      memory accepts request
//  mem_req_wen_o    out  1      1 = write
//  mem_req_addr_o   out  XLEN   address, low OFS_W bits zero
//  mem_req_wmask_o  out  NB     byte-lane strobe (write only; 0 for reads)
//  mem_req_wdata_o  out  XLEN   lane-shifted store data
//  mem_rsp_valid_i  in   1      response / write ack
//  mem_rsp_rdata_i  in   XLEN   read data, full aligned word
//  mem_rsp_err_i    in   1      bus error, qualified by mem_rsp_valid_i
// BEHAVIOUR
//  - FSM IDLE->REQ->WAIT->DONE->IDLE. in_ready_o = (state==IDLE). One op in flight.
//  - Reset: state IDLE; all outputs 0; regs and counter cleared. Mid-op reset drops
//    mem_req_valid_o immediately; responses arriving later are ignored.
//  - IDLE accept: latch all inputs. Non-memory op (load=store=0) -> DONE next cycle,
//    rd_data_o = alu_res. Illegal info -> DONE with err, no memory request:
//    load&store both set, not exactly one size bit, or dw with XLEN=32.
//  - REQ: mem_req_* driven from registers and held stable until mem_req_ready_i;
//    on handshake -> WAIT, counter = 0.
//  - WAIT: on mem_rsp_valid_i -> DONE; capture rdata and err = mem_rsp_err_i.
//    Counter +1 per cycle; at TIMEOUT_CYC-1 with no response -> DONE, err = 1.
//    mem_rsp_valid_i outside WAIT is ignored.
//  - Lanes: ofs = addr[OFS_W-1:0]; size mask b/h/w/d = 1/3/F/FF; wmask = mask<<ofs
//    truncated to NB; wdata = rs2 << (8*ofs).
//  - Load: sh = rdata >> (8*ofs); lb/lh/lw sign-extend sh[7/15/31]; lbu/lhu/lwu
//    zero-extend; ld = full 64 bits.
//  - DONE: out_valid_o=1, outputs stable until out_ready_i -> IDLE. The next op is
//    accepted no earlier than the following cycle. Error: rd_wr_en_o=0, lsu_err_o=1.
//  - Minimum latency: pass-through 1 cycle in->out_valid; memory op 3 cycles with
//    zero-wait memory.
// CONFIGURATION
//  YSYX_22040237_LSU_MISALIGN_CHK_EN
//   defined: access with addr not a multiple of its size (h:2, w:4, d:8) -> DONE
//    with err after 1 cycle, no memory request issued.
//   undefined: no check; a lane overflow past NB is truncated silently in
//    wmask/wdata, and high load bytes read as 0 before extension.
// TESTING
//  1 XLEN=64, lb addr 0x8000_0003, rdata 0x0000_0000_80FF_0000 ->
//    req addr 0x8000_0000, rd_data 0xFFFF_FFFF_FFFF_FF80
//  2 sw addr 0x8000_0004, rs2 0x1122_3344 -> wmask 0xF0,
//    wdata 0x1122_3344_0000_0000, wen=1
//  3 ld addr 0x10, rdata 0x8877_6655_4433_2211, out_ready low 3 cycles ->
//    rd_data 0x8877_6655_4433_2211, held stable until out_ready
//  4 mem_req_ready low 5 cycles -> req fields stable throughout; one handshake only
//  5 TIMEOUT_CYC=4, no response -> err=1 and rd_wr_en_o=0 after 4 WAIT cycles;
//    a later rsp_valid is ignored
//  6 CHK_EN defined, lw addr 0x2 -> err next cycle, mem_req_valid never asserted;
//    with rst mid-WAIT -> IDLE, all outputs 0

Source files
------------

// File: rtl/ysyx_22040237_lsu_mc.sv
// Multi-cycle load/store unit between EXU and WBU with a handshaked memory port.
// Optional misalignment trap: define YSYX_22040237_LSU_MISALIGN_CHK_EN.
module ysyx_22040237_lsu_mc #(
    parameter int XLEN        = 64,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                rd_wr_en_i,
    input  logic [4:0]          rd_idx_i,
    input  logic [XLEN-1:0]     alu_res_i,
    input  logic [6:0]          ls_info_bus_i,
    input  logic [XLEN-1:0]     rs2_store_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                rd_wr_en_o,
    output logic [4:0]          rd_idx_o,
    output logic [XLEN-1:0]     rd_data_o,
    output logic                lsu_err_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic                mem_req_wen_o,
    output logic [XLEN-1:0]     mem_req_addr_o,
    output logic [XLEN/8-1:0]   mem_req_wmask_o,
    output logic [XLEN-1:0]     mem_req_wdata_o,
    input  logic                mem_rsp_valid_i,
    input  logic [XLEN-1:0]     mem_rsp_rdata_i,
    input  logic                mem_rsp_err_i
);
    localparam int NB    = XLEN / 8;
    localparam int OFS_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TO_EN = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             op_wen_q, op_load_q;
    logic [4:0]       op_info_q;
    logic [OFS_W-1:0] op_ofs_q;
    logic             req_valid_q, req_wen_q;
    logic [XLEN-1:0]  req_addr_q, req_wdata_q;
    logic [NB-1:0]    req_wmask_q;
    logic             out_valid_q, out_wen_q, out_err_q;
    logic [4:0]       out_idx_q;
    logic [XLEN-1:0]  out_data_q;

    logic             is_ld_d, is_st_d, is_mem_d, bad_d, mis_d;
    logic [7:0]       size_mask_d;
    logic [OFS_W-1:0] in_ofs_d;
    logic [NB-1:0]    wmask_d;
    logic [XLEN-1:0]  wdata_d, req_addr_d, sh_d, ld_data_d;
    logic [63:0]      sh64_d, ext_d;

    assign is_ld_d  = ls_info_bus_i[0];
    assign is_st_d  = ls_info_bus_i[1];
    assign is_mem_d = is_ld_d | is_st_d;
    assign bad_d    = (is_ld_d & is_st_d)
                    | (is_mem_d & ~$onehot(ls_info_bus_i[6:3]))
                    | (is_mem_d & ls_info_bus_i[6] & (XLEN == 32));

`ifdef YSYX_22040237_LSU_MISALIGN_CHK_EN
    assign mis_d = is_mem_d & ((ls_info_bus_i[4] & alu_res_i[0])
                 | (ls_info_bus_i[5] & |alu_res_i[1:0])
                 | (ls_info_bus_i[6] & |alu_res_i[2:0]));
`else
    assign mis_d = 1'b0;
`endif

    assign size_mask_d = ls_info_bus_i[6] ? 8'hFF :
                         ls_info_bus_i[5] ? 8'h0F :
                         ls_info_bus_i[4] ? 8'h03 : 8'h01;
    assign in_ofs_d    = alu_res_i[OFS_W-1:0];
    assign wmask_d     = NB'(size_mask_d) << in_ofs_d;
    assign wdata_d     = rs2_store_i << {in_ofs_d, 3'b000};
    assign req_addr_d  = {alu_res_i[XLEN-1:OFS_W], {OFS_W{1'b0}}};

    assign sh_d   = mem_rsp_rdata_i >> {op_ofs_q, 3'b000};
    assign sh64_d = 64'(sh_d);

    // Size selection and sign/zero extension of the lane-shifted load data
    always_comb begin
        ext_d = sh64_d;
        if (op_info_q[1])
            ext_d = {{56{~op_info_q[0] & sh64_d[7]}}, sh64_d[7:0]};
        else if (op_info_q[2])
            ext_d = {{48{~op_info_q[0] & sh64_d[15]}}, sh64_d[15:0]};
        else if (op_info_q[3])
            ext_d = {{32{~op_info_q[0] & sh64_d[31]}}, sh64_d[31:0]};
    end

    assign ld_data_d = ext_d[XLEN-1:0];

    // Operation FSM with all outputs held in registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_wen_q    <= 1'b0;
            op_load_q   <= 1'b0;
            op_info_q   <= '0;
            op_ofs_q    <= '0;
            req_valid_q <= 1'b0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wmask_q <= '0;
            req_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_wen_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (in_valid_i) begin
                    op_wen_q  <= rd_wr_en_i;
                    op_load_q <= is_ld_d;
                    op_info_q <= ls_info_bus_i[6:2];
                    op_ofs_q  <= in_ofs_d;
                    out_idx_q <= rd_idx_i;
                    if (bad_d || mis_d) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b1;
                        out_wen_q   <= 1'b0;
                        out_data_q  <= '0;
                    end else if (!is_mem_d) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b0;
                        out_wen_q   <= rd_wr_en_i;
                        out_data_q  <= alu_res_i;
                    end else begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                        req_wen_q   <= is_st_d;
                        req_addr_q  <= req_addr_d;
                        req_wmask_q <= is_st_d ? wmask_d : '0;
                        req_wdata_q <= is_st_d ? wdata_d : '0;
                    end
                end
                S_REQ: if (mem_req_ready_i) begin
                    state_q     <= S_WAIT;
                    req_valid_q <= 1'b0;
                    cnt_q       <= '0;
                end
                S_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_err_q   <= mem_rsp_err_i;
                        out_wen_q   <= op_wen_q & ~mem_rsp_err_i;
                        out_data_q  <= (op_load_q && !mem_rsp_err_i) ? ld_data_d : '0;
                    end else if (TO_EN && cnt_q == CNT_LAST) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b1;
                        out_wen_q   <= 1'b0;
                        out_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: if (out_ready_i) begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o      = (state_q == S_IDLE);
    assign out_valid_o     = out_valid_q;
    assign rd_wr_en_o      = out_wen_q;
    assign rd_idx_o        = out_idx_q;
    assign rd_data_o       = out_data_q;
    assign lsu_err_o       = out_err_q;
    assign mem_req_valid_o = req_valid_q & ~rst;
    assign mem_req_wen_o   = req_wen_q;
    assign mem_req_addr_o  = req_addr_q;
    assign mem_req_wmask_o = req_wmask_q;
    assign mem_req_wdata_o = req_wdata_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu_mc.sv
// Directed bench for ysyx_22040237_lsu_mc (XLEN=64, TIMEOUT_CYC=4).
// Misalignment vectors follow YSYX_22040237_LSU_MISALIGN_CHK_EN.
module tb_ysyx_22040237_lsu_mc;
    logic        clk;
    logic        rst;
    logic        in_valid_i, in_ready_o;
    logic        rd_wr_en_i;
    logic [4:0]  rd_idx_i;
    logic [63:0] alu_res_i;
    logic [6:0]  ls_info_bus_i;
    logic [63:0] rs2_store_i;
    logic        out_valid_o, out_ready_i;
    logic        rd_wr_en_o;
    logic [4:0]  rd_idx_o;
    logic [63:0] rd_data_o;
    logic        lsu_err_o;
    logic        mem_req_valid_o, mem_req_ready_i, mem_req_wen_o;
    logic [63:0] mem_req_addr_o;
    logic [7:0]  mem_req_wmask_o;
    logic [63:0] mem_req_wdata_o;
    logic        mem_rsp_valid_i;
    logic [63:0] mem_rsp_rdata_i;
    logic        mem_rsp_err_i;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int req_seen = 0;
    int h0;
    int r0;

    ysyx_22040237_lsu_mc #(.XLEN(64), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i),
        .alu_res_i(alu_res_i), .ls_info_bus_i(ls_info_bus_i),
        .rs2_store_i(rs2_store_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .rd_wr_en_o(rd_wr_en_o), .rd_idx_o(rd_idx_o),
        .rd_data_o(rd_data_o), .lsu_err_o(lsu_err_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_wen_o(mem_req_wen_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wmask_o(mem_req_wmask_o), .mem_req_wdata_o(mem_req_wdata_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
        .mem_rsp_err_i(mem_rsp_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count request handshakes and cycles with a request pending
    always @(posedge clk) begin
        if (mem_req_valid_o && mem_req_ready_i) hs_cnt <= hs_cnt + 1;
        if (mem_req_valid_o) req_seen <= req_seen + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] info, input logic [63:0] addr,
                         input logic [63:0] rs2, input logic wen, input logic [4:0] idx);
        in_valid_i    = 1'b1;
        ls_info_bus_i = info;
        alu_res_i     = addr;
        rs2_store_i   = rs2;
        rd_wr_en_i    = wen;
        rd_idx_i      = idx;
        step();
        in_valid_i    = 1'b0;
    endtask

    task automatic respond(input logic [63:0] rdata, input logic err);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = rdata;
        mem_rsp_err_i   = err;
        step();
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid_i = 1'b0; rd_wr_en_i = 1'b0; rd_idx_i = '0;
        alu_res_i = '0; ls_info_bus_i = '0; rs2_store_i = '0;
        out_ready_i = 1'b1; mem_req_ready_i = 1'b1;
        mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = '0; mem_rsp_err_i = 1'b0;
        step(); step();
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_req_valid", mem_req_valid_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_err", lsu_err_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        rst = 1'b0;
        step();

        // lb with sign extension, minimum 3-cycle latency
        issue(7'b0001001, 64'h8000_0003, 64'h0, 1'b1, 5'd3);
        chk("lb_req_valid", mem_req_valid_o, 1);
        chk("lb_req_addr", mem_req_addr_o, 64'h8000_0000);
        chk("lb_req_wen", mem_req_wen_o, 0);
        chk("lb_req_wmask", mem_req_wmask_o, 0);
        step();
        chk("lb_wait_valid", out_valid_o, 0);
        respond(64'h0000_0000_80FF_0000, 1'b0);
        chk("lb_out_valid", out_valid_o, 1);
        chk("lb_rd_data", rd_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_rd_idx", rd_idx_o, 3);
        chk("lb_wen", rd_wr_en_o, 1);
        step();
        chk("lb_back_idle", in_ready_o, 1);

        // sw into the upper word lanes
        issue(7'b0100010, 64'h8000_0004, 64'h1122_3344, 1'b0, 5'd0);
        chk("sw_wen", mem_req_wen_o, 1);
        chk("sw_addr", mem_req_addr_o, 64'h8000_0000);
        chk("sw_wmask", mem_req_wmask_o, 8'hF0);
        chk("sw_wdata", mem_req_wdata_o, 64'h1122_3344_0000_0000);
        step();
        respond(64'h0, 1'b0);
        chk("sw_done", out_valid_o, 1);
        chk("sw_err", lsu_err_o, 0);
        chk("sw_rd_wen", rd_wr_en_o, 0);
        step();

        // ld with WBU back-pressure
        out_ready_i = 1'b0;
        issue(7'b1000001, 64'h10, 64'h0, 1'b1, 5'd7);
        step();
        respond(64'h8877_6655_4433_2211, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("ld_hold_valid", out_valid_o, 1);
            chk("ld_hold_data", rd_data_o, 64'h8877_6655_4433_2211);
            step();
        end
        out_ready_i = 1'b1;
        chk("ld_last_data", rd_data_o, 64'h8877_6655_4433_2211);
        step();
        chk("ld_released", out_valid_o, 0);

        // lhu with memory request back-pressure
        mem_req_ready_i = 1'b0;
        h0 = hs_cnt;
        issue(7'b0010101, 64'h22, 64'h0, 1'b1, 5'd9);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req_valid", mem_req_valid_o, 1);
            chk("stall_req_addr", mem_req_addr_o, 64'h20);
            step();
        end
        mem_req_ready_i = 1'b1;
        step();
        chk("stall_req_dropped", mem_req_valid_o, 0);
        chk("stall_one_hs", 64'(hs_cnt - h0), 1);
        respond(64'h0000_0000_ABCD_0000, 1'b0);
        chk("lhu_rd_data", rd_data_o, 64'h0000_0000_0000_ABCD);
        step();

        // Response timeout after 4 WAIT cycles, late response ignored
        out_ready_i = 1'b0;
        issue(7'b0100001, 64'h40, 64'h0, 1'b1, 5'd4);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_not_yet", out_valid_o, 0);
        end
        step();
        chk("to_valid", out_valid_o, 1);
        chk("to_err", lsu_err_o, 1);
        chk("to_rd_wen", rd_wr_en_o, 0);
        respond(64'h1234, 1'b0);
        chk("to_late_err", lsu_err_o, 1);
        chk("to_late_data", rd_data_o, 0);
        out_ready_i = 1'b1;
        step();
        respond(64'h5678, 1'b0);
        chk("to_idle_valid", out_valid_o, 0);
        chk("to_idle_ready", in_ready_o, 1);

        // Bus error on a load
        issue(7'b0001101, 64'h5, 64'h0, 1'b1, 5'd2);
        step();
        respond(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        chk("buserr_err", lsu_err_o, 1);
        chk("buserr_wen", rd_wr_en_o, 0);
        step();

        // Non-memory pass-through in one cycle
        issue(7'b0000000, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b1, 5'd31);
        chk("pt_valid", out_valid_o, 1);
        chk("pt_data", rd_data_o, 64'hDEAD_BEEF_0123_4567);
        chk("pt_idx", rd_idx_o, 31);
        chk("pt_wen", rd_wr_en_o, 1);
        chk("pt_no_req", mem_req_valid_o, 0);
        step();

        // Illegal encodings trap without a memory request
        r0 = req_seen;
        issue(7'b0100011, 64'h100, 64'h0, 1'b1, 5'd1);
        chk("ldst_err", lsu_err_o, 1);
        chk("ldst_valid", out_valid_o, 1);
        chk("ldst_wen", rd_wr_en_o, 0);
        step();
        issue(7'b0110001, 64'h100, 64'h0, 1'b1, 5'd1);
        chk("twosize_err", lsu_err_o, 1);
        step();
        chk("illegal_no_req", 64'(req_seen - r0), 0);

`ifdef YSYX_22040237_LSU_MISALIGN_CHK_EN
        r0 = req_seen;
        issue(7'b0100001, 64'h2, 64'h0, 1'b1, 5'd6);
        chk("mis_lw_valid", out_valid_o, 1);
        chk("mis_lw_err", lsu_err_o, 1);
        step();
        chk("mis_no_req", 64'(req_seen - r0), 0);
`else
        issue(7'b0100001, 64'h2, 64'h0, 1'b1, 5'd6);
        chk("unal_lw_addr", mem_req_addr_o, 64'h0);
        step();
        respond(64'h1122_3344_8899_AABB, 1'b0);
        chk("unal_lw_data", rd_data_o, 64'h0000_0000_3344_8899);
        step();
        issue(7'b0100010, 64'h6, 64'hAABB_CCDD, 1'b0, 5'd0);
        chk("ovf_sw_wmask", mem_req_wmask_o, 8'hC0);
        chk("ovf_sw_wdata", mem_req_wdata_o, 64'hCCDD_0000_0000_0000);
        step();
        respond(64'h0, 1'b0);
        step();
`endif

        // Reset while a request is pending
        mem_req_ready_i = 1'b0;
        issue(7'b1000001, 64'h8, 64'h0, 1'b1, 5'd12);
        chk("rreq_valid", mem_req_valid_o, 1);
        rst = 1'b1;
        #1;
        chk("rreq_drop", mem_req_valid_o, 0);
        step();
        rst = 1'b0;
        mem_req_ready_i = 1'b1;
        chk("rreq_idle", in_ready_o, 1);
        chk("rreq_out_valid", out_valid_o, 0);

        // Reset mid-WAIT, later response ignored
        issue(7'b1000001, 64'h8, 64'h0, 1'b1, 5'd12);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rwait_idle", in_ready_o, 1);
        chk("rwait_idx", rd_idx_o, 0);
        chk("rwait_err", lsu_err_o, 0);
        respond(64'hFFFF, 1'b0);
        chk("rwait_ignore_valid", out_valid_o, 0);
        chk("rwait_ignore_data", rd_data_o, 0);
        chk("rwait_ready", in_ready_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
